calculadora_arbitro: RTL and testbench

CALCULADORA_ARBITRO -- requirements
Module: calculadora_arbitro

---
 rtl/calculadora_arbitro.sv | 161 ++++++++++++++++
 tb/tb_calculadora_arbitro.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/calculadora_arbitro.sv
// Two-requester round-robin arbiter in front of an 8-bit calculator.
// One operation is in flight at a time, and each result is held until the consumer acks it.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  OCIOSO  | idle; arbitrate pending requests, latch winner operands
//  CALCULA | compute the latched operation, register the result
//  ENTREGA | result valid; hold outputs until ack, then count delivery
module calculadora_arbitro (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [2:0] cod0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [2:0] cod1,
    input  logic       ack,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] resultado,
    output logic       carry,
    output logic       erro,
    output logic       valido,
    output logic       origem,
    output logic [7:0] total
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic [2:0] COD_A   = 3'b001;
    localparam logic [2:0] COD_B   = 3'b010;
    localparam logic [2:0] COD_SOMA = 3'b011;
    localparam logic [2:0] COD_SUB = 3'b100;

    estado_t    estado;
    estado_t    prox_estado;

    logic       ultimo;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] op_cod;

    logic       vence0;
    logic       vence1;
    logic       lancar;
    logic       aceitar;
    logic       registra;

    logic [8:0] soma9;
    logic [8:0] dif9;
    logic [7:0] res_calc;
    logic       carry_calc;
    logic       erro_calc;

    // On a tie the requester that was not served last wins.
    always_comb begin
        vence1 = req1 & (~req0 | ~ultimo);
        vence0 = req0 & ~vence1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        lancar      = 1'b0;
        registra    = 1'b0;
        aceitar     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (req0 | req1) begin
                    lancar      = 1'b1;
                    prox_estado = CALCULA;
                end
            end
            CALCULA: begin
                registra    = 1'b1;
                prox_estado = ENTREGA;
            end
            ENTREGA: begin
                if (ack) begin
                    aceitar     = 1'b1;
                    prox_estado = OCIOSO;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // The borrow of the subtraction falls out of bit 8 of the 9-bit difference.
    always_comb begin
        soma9      = {1'b0, op_a} + {1'b0, op_b};
        dif9       = {1'b0, op_a} - {1'b0, op_b};
        res_calc   = 8'h00;
        carry_calc = 1'b0;
        erro_calc  = 1'b0;
        case (op_cod)
            COD_A:    res_calc = op_a;
            COD_B:    res_calc = op_b;
            COD_SOMA: begin
                res_calc   = soma9[7:0];
                carry_calc = soma9[8];
            end
            COD_SUB: begin
                res_calc   = dif9[7:0];
                carry_calc = dif9[8];
            end
            default:  erro_calc = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            op_cod    <= 3'b000;
            origem    <= 1'b0;
            ultimo    <= 1'b1;
            resultado <= 8'h00;
            carry     <= 1'b0;
            erro      <= 1'b0;
            valido    <= 1'b0;
            total     <= 8'h00;
        end else begin
            gnt0 <= lancar & vence0;
            gnt1 <= lancar & vence1;
            if (lancar) begin
                origem <= vence1;
                op_a   <= vence1 ? a1 : a0;
                op_b   <= vence1 ? b1 : b0;
                op_cod <= vence1 ? cod1 : cod0;
            end
            if (registra) begin
                resultado <= res_calc;
                carry     <= carry_calc;
                erro      <= erro_calc;
                valido    <= 1'b1;
            end
            if (aceitar) begin
                valido <= 1'b0;
                ultimo <= origem;
                total  <= total + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_calculadora_arbitro.sv
// Directed and randomized checks of calculadora_arbitro against a
// transaction-level model of arbitration, arithmetic and delivery count.
module tb_calculadora_arbitro;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, ack;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] cod0, cod1;
    logic       gnt0, gnt1, carry, erro, valido, origem;
    logic [7:0] resultado, total;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int g_cyc      = 0;
    int m_ultimo;
    int m_total;

    calculadora_arbitro dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cod0(cod0),
        .req1(req1), .a1(a1), .b1(b1), .cod1(cod1),
        .gnt0(gnt0), .gnt1(gnt1),
        .resultado(resultado), .carry(carry), .erro(erro),
        .valido(valido), .origem(origem), .ack(ack), .total(total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {erro, carry, resultado} from the operation table.
    function automatic logic [9:0] ref_op(input int a, input int b, input int cod);
        int r, c, e;
        r = 0; c = 0; e = 0;
        case (cod)
            1: r = a;
            2: r = b;
            3: begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            4: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            default: e = 1;
        endcase
        return {e[0], c[0], r[7:0]};
    endfunction

    task automatic scramble();
        req0 = 1'($urandom_range(0, 1));
        req1 = 1'($urandom_range(0, 1));
        a0 = 8'($urandom); b0 = 8'($urandom); cod0 = 3'($urandom);
        a1 = 8'($urandom); b1 = 8'($urandom); cod1 = 3'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ultimo = 1;
        m_total  = 0;
    endtask

    // Full transaction: grant, compute, 'espera' cycles of backpressure, ack.
    task automatic do_op(input logic r0, input logic r1,
                         input logic [7:0] xa0, input logic [7:0] xb0, input logic [2:0] xc0,
                         input logic [7:0] xa1, input logic [7:0] xb1, input logic [2:0] xc1,
                         input int espera, output int vencedor);
        int w;
        logic [9:0] e;
        req0 = r0; req1 = r1;
        a0 = xa0; b0 = xb0; cod0 = xc0;
        a1 = xa1; b1 = xb1; cod1 = xc1;
        ack = 1'($urandom_range(0, 1));
        if (r0 && r1) w = 1 - m_ultimo;
        else w = r1 ? 1 : 0;
        e = (w == 1) ? ref_op(int'(xa1), int'(xb1), int'(xc1))
                     : ref_op(int'(xa0), int'(xb0), int'(xc0));
        step();
        g_cyc = cyc;
        chk("gnt0", gnt0, (w == 0) ? 1 : 0);
        chk("gnt1", gnt1, (w == 1) ? 1 : 0);
        chk("origem_gnt", origem, w);
        chk("valido_gnt", valido, 0);
        scramble();
        ack = 1'($urandom_range(0, 1));
        step();
        chk("valido", valido, 1);
        chk("resultado", resultado, e[7:0]);
        chk("carry", carry, e[8]);
        chk("erro", erro, e[9]);
        chk("origem", origem, w);
        chk("gnt_calc", {gnt1, gnt0}, 0);
        for (int i = 0; i < espera; i++) begin
            ack = 1'b0;
            scramble();
            step();
            chk("hold_valido", valido, 1);
            chk("hold_resultado", resultado, e[7:0]);
            chk("hold_origem", origem, w);
            chk("hold_gnt", {gnt1, gnt0}, 0);
            chk("hold_total", total, m_total);
        end
        ack = 1'b1;
        step();
        m_total  = (m_total + 1) % 256;
        m_ultimo = w;
        chk("valido_ack", valido, 0);
        chk("total", total, m_total);
        chk("retido_resultado", resultado, e[7:0]);
        chk("retido_origem", origem, w);
        chk("gnt_ack", {gnt1, gnt0}, 0);
        vencedor = w;
    endtask

    initial begin
        int w, pc, r0, r1;
        rst = 1'b0; ack = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'h00; b0 = 8'h00; cod0 = 3'b000;
        a1 = 8'h00; b1 = 8'h00; cod1 = 3'b000;
        step();
        do_reset();

        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_valido", valido, 0);
        chk("rst_resultado", resultado, 0);
        chk("rst_carry", carry, 0);
        chk("rst_erro", erro, 0);
        chk("rst_origem", origem, 0);
        chk("rst_total", total, 0);

        // Idle with no requests; ack must be ignored.
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_gnt", {gnt1, gnt0}, 0);
            chk("idle_valido", valido, 0);
            chk("idle_total", total, 0);
        end

        // Reset and tie: requester 0 wins first.
        do_op(1, 1, 8'h05, 8'h03, 3'b011, 8'h77, 8'h11, 3'b001, 0, w);
        chk("tie_total", total, 1);

        // Fairness from a fresh reset.
        do_reset();
        pc = 0;
        for (int i = 0; i < 4; i++) begin
            do_op(1, 1, 8'($urandom), 8'($urandom), 3'b011,
                  8'($urandom), 8'($urandom), 3'b100, 0, w);
            if (i > 0) chk("grant_spacing", g_cyc - pc, 3);
            pc = g_cyc;
        end

        // Arithmetic edges.
        do_op(1, 0, 8'hFF, 8'h01, 3'b011, 8'h00, 8'h00, 3'b000, 0, w);
        do_op(0, 1, 8'h00, 8'h00, 3'b000, 8'h03, 8'h05, 3'b100, 0, w);
        do_op(1, 0, 8'h12, 8'h34, 3'b111, 8'h00, 8'h00, 3'b000, 0, w);
        do_op(0, 1, 8'h00, 8'h00, 3'b000, 8'h5A, 8'hA5, 3'b010, 0, w);
        do_op(1, 0, 8'h3C, 8'hC3, 3'b001, 8'h00, 8'h00, 3'b000, 0, w);
        do_op(0, 1, 8'h00, 8'h00, 3'b000, 8'h01, 8'h02, 3'b000, 0, w);

        // Backpressure.
        do_op(1, 1, 8'h40, 8'h02, 3'b100, 8'h90, 8'h90, 3'b011, 10, w);

        // Reset in CALCULA.
        req0 = 1'b1; req1 = 1'b1; ack = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ultimo = 1; m_total = 0;
        chk("rstc_valido", valido, 0);
        chk("rstc_total", total, 0);
        chk("rstc_gnt", {gnt1, gnt0}, 0);

        // Reset in ENTREGA.
        do_op(0, 1, 8'h00, 8'h00, 3'b000, 8'h10, 8'h20, 3'b011, 0, w);
        req0 = 1'b0; req1 = 1'b1; ack = 1'b0;
        step();
        step();
        chk("pre_rste_valido", valido, 1);
        rst = 1'b1; req0 = 1'b1;
        step();
        rst = 1'b0;
        m_ultimo = 1; m_total = 0;
        chk("rste_valido", valido, 0);
        chk("rste_total", total, 0);
        chk("rste_gnt", {gnt1, gnt0}, 0);
        do_op(1, 1, 8'h07, 8'h02, 3'b100, 8'hEE, 8'h01, 3'b011, 0, w);

        // Random operations through the counter wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            r0 = int'($urandom_range(0, 1));
            r1 = (r0 == 1) ? int'($urandom_range(0, 1)) : 1;
            do_op(1'(r0), 1'(r1), 8'($urandom), 8'($urandom), 3'($urandom),
                  8'($urandom), 8'($urandom), 3'($urandom),
                  int'($urandom_range(0, 2)), w);
        end
        chk("wrap_total", total, 0);
        do_op(1, 0, 8'h01, 8'h01, 3'b011, 8'h00, 8'h00, 3'b000, 0, w);
        chk("wrap_total_plus1", total, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
